rf_wb_scheduler: RTL and testbench
==================================

// Module: rf_wb_scheduler
// PURPOSE
//  Schedules the single register-file write port between two writeback requesters
//  (ALU, LSU) and tracks a per-register busy scoreboard for in-flight destinations.
//  Sits between the execute/memory stages and r_file_memory. Drives writeEn/writeAddr/
//  writeData and reports rs1/rs2 busy to decode for RAW stalls and issue stalls for WAW.
// PARAMETERS
//  NumEntries  32  register count; RW = $clog2(NumEntries), AW = $clog2(NumEntries<<2)
// PORTS
//  clk_100MHz    in   1   clock
//  reset         in   1   synchronous, active-high
//  issue_valid   in   1   decode claims destination issue_rd
//  issue_rd      in   RW  destination register index
//  issue_ready   out  1   claim accepted this cycle
//  rs1, rs2      in   RW  decode source indices
//  rs1_busy      out  1   busy[rs1] (comb); always 0 for index 0
//  rs2_busy      out  1   busy[rs2] (comb); always 0 for index 0
//  alu_valid     in   1   ALU writeback request
//  alu_rd        in   RW  ALU destination
//  alu_data      in   32  ALU result
//  alu_ready     out  1   ALU request accepted this cycle
//  lsu_valid     in   1   LSU writeback request
//  lsu_rd        in   RW  LSU destination
//  lsu_data      in   32  load result
//  lsu_ready     out  1   LSU request accepted this cycle
//  rf_writeEn    out  1   to register file writeEn (registered)
//  rf_writeAddr  out  AW  byte address {rd,2'b00} (registered)
//  rf_writeData  out  32  write data (registered)
// BEHAVIOUR
//  - Reset: busy vector all 0; rf_writeEn=0, rf_writeAddr=0, rf_writeData=0; last_grant=ALU.
//    Reset mid-operation discards all in-flight claims and the pending output write.
//  - issue_ready = issue_valid & ~busy[issue_rd] (comb). issue_rd==0 -> always ready, no set.
//  - Arbitration (comb): exactly one of alu_ready/lsu_ready per cycle; ready only if valid.
//    One valid -> it wins. Both valid -> per CONFIGURATION. last_grant updates on each grant.
//  - Accepted request -> next cycle: rf_writeEn=1, rf_writeAddr={rd,2'b00}, rf_writeData=data.
//    Latency 1 cycle, throughput 1 write/cycle; no grant -> rf_writeEn=0 next cycle, addr/data hold.
//  - Accepted request with rd==0: handshake completes, rf_writeEn stays 0 (x0 never written).
//  - busy[rd] clears at the clock edge where rf_writeEn=1 for rd (same edge the register file
//    captures data); rs*_busy reads 0 from the following cycle, when readData is already new.
//  - busy[issue_rd] sets at the edge where issue handshake occurs (rd!=0).
//  - Same index set and clear at one edge: set wins (new claim survives).
//  - Writeback to a non-busy rd: still written; busy unchanged.
//  - Arithmetic: rf_writeAddr = rd zero-extended and shifted left 2; no truncation for AW=RW+2.
// CONFIGURATION
//  RF_WB_RR_EN defined: round-robin on conflict; winner is the requester not in last_grant.
//  RF_WB_RR_EN undefined: fixed priority, LSU always wins on conflict; last_grant unused.
// TESTING
//  1 reset; issue rd=5; next cycle rs1=5 -> rs1_busy=1, issue_ready=0 for issue_rd=5.
//  2 alu_valid rd=5 data=0xDEADBEEF -> alu_ready=1; next cycle rf_writeEn=1, addr=0x14,
//    data=0xDEADBEEF; cycle after rs1_busy=0 for rs1=5.
//  3 alu rd=3 and lsu rd=4 valid 4 cycles: RR_EN -> grants LSU,ALU,LSU,ALU;
//    no RR_EN -> LSU every cycle, alu_ready=0 throughout.
//  4 lsu_valid rd=0 data=0x1234 -> lsu_ready=1, rf_writeEn=0 next cycle; rs1=0 -> busy=0.
//  5 rf_writeEn=1 for rd=7 while issue rd=7 same cycle -> busy[7]=1 after edge.
//  6 claim rd=9, assert reset for 1 cycle mid-flight -> busy all 0, rf_writeEn=0 next cycle.

Source files
------------

// File: rtl/rf_wb_scheduler.sv
// Register-file writeback scheduler: arbitrates ALU/LSU onto the single write port
// and tracks a per-register busy scoreboard. Optional round-robin arbitration: RF_WB_RR_EN.
module rf_wb_scheduler #(
  parameter int NumEntries = 32,
  localparam int RW = $clog2(NumEntries),
  localparam int AW = $clog2(NumEntries << 2)
) (
  input  logic          clk_100MHz,
  input  logic          reset,
  input  logic          issue_valid,
  input  logic [RW-1:0] issue_rd,
  output logic          issue_ready,
  input  logic [RW-1:0] rs1,
  input  logic [RW-1:0] rs2,
  output logic          rs1_busy,
  output logic          rs2_busy,
  input  logic          alu_valid,
  input  logic [RW-1:0] alu_rd,
  input  logic [31:0]   alu_data,
  output logic          alu_ready,
  input  logic          lsu_valid,
  input  logic [RW-1:0] lsu_rd,
  input  logic [31:0]   lsu_data,
  output logic          lsu_ready,
  output logic          rf_writeEn,
  output logic [AW-1:0] rf_writeAddr,
  output logic [31:0]   rf_writeData
);

  // Handshakes (issue, alu, lsu): a transfer happens on a cycle where valid and ready
  // are both high; ready is combinational and is never asserted without its valid.

  logic [NumEntries-1:0] busy;
  logic [NumEntries-1:0] busy_next;
  logic [RW-1:0]         wb_rd_q;
  logic                  grant;
  logic [RW-1:0]         grant_rd;
  logic [31:0]           grant_data;

`ifdef RF_WB_RR_EN
  typedef enum logic {GRANT_ALU, GRANT_LSU} grant_e;
  grant_e last_grant;
`endif

  assign rs1_busy    = (rs1 != '0) && busy[rs1];
  assign rs2_busy    = (rs2 != '0) && busy[rs2];
  assign issue_ready = issue_valid && !busy[issue_rd];

  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (alu_valid && lsu_valid) begin
`ifdef RF_WB_RR_EN
      if (last_grant == GRANT_ALU) lsu_ready = 1'b1;
      else                         alu_ready = 1'b1;
`else
      lsu_ready = 1'b1;
`endif
    end else if (alu_valid) begin
      alu_ready = 1'b1;
    end else if (lsu_valid) begin
      lsu_ready = 1'b1;
    end
  end

  assign grant      = alu_ready || lsu_ready;
  assign grant_rd   = lsu_ready ? lsu_rd   : alu_rd;
  assign grant_data = lsu_ready ? lsu_data : alu_data;

  // Clear on the write edge first, then a new claim on the same index overrides it.
  always_comb begin
    busy_next = busy;
    if (rf_writeEn) busy_next[wb_rd_q] = 1'b0;
    if (issue_ready && (issue_rd != '0)) busy_next[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      busy         <= '0;
      rf_writeEn   <= 1'b0;
      wb_rd_q      <= '0;
      rf_writeData <= '0;
    end else begin
      busy       <= busy_next;
      rf_writeEn <= grant && (grant_rd != '0);
      // x0 writebacks complete the handshake but leave the port idle and addr/data held.
      if (grant && (grant_rd != '0)) begin
        wb_rd_q      <= grant_rd;
        rf_writeData <= grant_data;
      end
    end
  end

`ifdef RF_WB_RR_EN
  always_ff @(posedge clk_100MHz) begin
    if (reset) last_grant <= GRANT_ALU;
    else if (grant) last_grant <= lsu_ready ? GRANT_LSU : GRANT_ALU;
  end
`endif

  assign rf_writeAddr = AW'({wb_rd_q, 2'b00});

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Self-checking bench for rf_wb_scheduler; expected writes go through a scoreboard queue.
module tb_rf_wb_scheduler;
  localparam int RW = 5;
  localparam int AW = 7;
  localparam int W  = AW + 32;
`ifdef RF_WB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk_100MHz = 1'b0;
  logic          reset = 1'b1;
  logic          issue_valid, issue_ready;
  logic [RW-1:0] issue_rd, rs1, rs2;
  logic          rs1_busy, rs2_busy;
  logic          alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [RW-1:0] alu_rd, lsu_rd;
  logic [31:0]   alu_data, lsu_data;
  logic          rf_writeEn;
  logic [AW-1:0] rf_writeAddr;
  logic [31:0]   rf_writeData;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit model_last_lsu;
  logic [W-1:0] exp_q[$];

  rf_wb_scheduler dut (
    .clk_100MHz(clk_100MHz), .reset(reset),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .rf_writeEn(rf_writeEn), .rf_writeAddr(rf_writeAddr), .rf_writeData(rf_writeData)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every observed write must match the oldest expected write.
  always @(negedge clk_100MHz) begin
    if (rf_writeEn === 1'b1) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected: write addr=%h data=%h, none expected", rf_writeAddr, rf_writeData);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({rf_writeAddr, rf_writeData} !== e)
          $display("FAIL sb_write: got addr=%h data=%h, expected addr=%h data=%h",
                   rf_writeAddr, rf_writeData, e[W-1:32], e[31:0]);
        else pass_cnt++;
      end
    end
  end

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_rd = '0; rs1 = '0; rs2 = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
  endtask

  task automatic push_write(input logic [RW-1:0] rd, input logic [31:0] data);
    logic [AW-1:0] a;
    a = {rd, 2'b00};
    exp_q.push_back({a, data});
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk_100MHz);
    reset = 1'b0;
    model_last_lsu = 1'b0;
    #1;
    total_cnt++;
    if ({rf_writeEn, rf_writeAddr, rf_writeData} !== '0)
      $display("FAIL reset_outputs: en=%b addr=%h data=%h, expected all 0", rf_writeEn, rf_writeAddr, rf_writeData);
    else pass_cnt++;
  endtask

  task automatic test_issue_busy();
    @(negedge clk_100MHz);
    issue_valid = 1'b1; issue_rd = 5; #1;
    total_cnt++;
    if (issue_ready !== 1'b1) $display("FAIL issue_free: issue_ready=%b expected 1", issue_ready);
    else pass_cnt++;
    @(negedge clk_100MHz);
    issue_valid = 1'b0; rs1 = 5; rs2 = 6; #1;
    total_cnt++;
    if ({rs1_busy, rs2_busy} !== 2'b10) $display("FAIL busy_set: rs1_busy,rs2_busy=%b expected 10", {rs1_busy, rs2_busy});
    else pass_cnt++;
    issue_valid = 1'b1; issue_rd = 5; #1;
    total_cnt++;
    if (issue_ready !== 1'b0) $display("FAIL issue_waw: issue_ready=%b expected 0", issue_ready);
    else pass_cnt++;
    issue_valid = 1'b0;
  endtask

  task automatic test_alu_write();
    @(negedge clk_100MHz);
    alu_valid = 1'b1; alu_rd = 5; alu_data = 32'hDEADBEEF; rs1 = 5; #1;
    total_cnt++;
    if ({alu_ready, lsu_ready} !== 2'b10) $display("FAIL alu_grant: alu,lsu ready=%b expected 10", {alu_ready, lsu_ready});
    else pass_cnt++;
    push_write(5, 32'hDEADBEEF);
    model_last_lsu = 1'b0;
    @(negedge clk_100MHz);
    alu_valid = 1'b0; #1;
    total_cnt++;
    if ({rf_writeEn, rf_writeAddr, rf_writeData} !== {1'b1, 7'h14, 32'hDEADBEEF})
      $display("FAIL alu_write: en=%b addr=%h data=%h expected 1 14 deadbeef", rf_writeEn, rf_writeAddr, rf_writeData);
    else pass_cnt++;
    total_cnt++;
    if (rs1_busy !== 1'b1) $display("FAIL busy_until_write: rs1_busy=%b expected 1", rs1_busy);
    else pass_cnt++;
    @(negedge clk_100MHz); #1;
    total_cnt++;
    if (rs1_busy !== 1'b0) $display("FAIL busy_clear: rs1_busy=%b expected 0", rs1_busy);
    else pass_cnt++;
    total_cnt++;
    if ({rf_writeEn, rf_writeAddr, rf_writeData} !== {1'b0, 7'h14, 32'hDEADBEEF})
      $display("FAIL idle_hold: en=%b addr=%h data=%h expected 0 14 deadbeef", rf_writeEn, rf_writeAddr, rf_writeData);
    else pass_cnt++;
  endtask

  task automatic test_conflict(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      bit win_lsu;
      @(negedge clk_100MHz);
      alu_valid = 1'b1; alu_rd = 3; alu_data = $urandom();
      lsu_valid = 1'b1; lsu_rd = 4; lsu_data = $urandom(); #1;
      win_lsu = RR ? !model_last_lsu : 1'b1;
      total_cnt++;
      if ({alu_ready, lsu_ready} !== {!win_lsu, win_lsu})
        $display("FAIL conflict_%0d: alu,lsu ready=%b expected %b", i, {alu_ready, lsu_ready}, {!win_lsu, win_lsu});
      else pass_cnt++;
      if (win_lsu) push_write(4, lsu_data);
      else         push_write(3, alu_data);
      model_last_lsu = win_lsu;
    end
    @(negedge clk_100MHz);
    idle_inputs();
  endtask

  task automatic test_rd0();
    lsu_valid = 1'b1; lsu_rd = 0; lsu_data = 32'h1234; #1;
    total_cnt++;
    if ({alu_ready, lsu_ready} !== 2'b01) $display("FAIL rd0_grant: alu,lsu ready=%b expected 01", {alu_ready, lsu_ready});
    else pass_cnt++;
    model_last_lsu = 1'b1;
    @(negedge clk_100MHz);
    lsu_valid = 1'b0; issue_valid = 1'b1; issue_rd = 0; rs1 = 0; #1;
    total_cnt++;
    if ({rf_writeEn, issue_ready, rs1_busy} !== 3'b010)
      $display("FAIL rd0_write: en,issue_ready,rs1_busy=%b expected 010", {rf_writeEn, issue_ready, rs1_busy});
    else pass_cnt++;
    @(negedge clk_100MHz);
    issue_valid = 1'b0; #1;
    total_cnt++;
    if (rs1_busy !== 1'b0) $display("FAIL rd0_busy: rs1_busy=%b expected 0", rs1_busy);
    else pass_cnt++;
  endtask

  task automatic test_set_clear_same_edge();
    @(negedge clk_100MHz);
    lsu_valid = 1'b1; lsu_rd = 7; lsu_data = $urandom();
    push_write(7, lsu_data);
    model_last_lsu = 1'b1;
    @(negedge clk_100MHz);
    lsu_valid = 1'b0; issue_valid = 1'b1; issue_rd = 7; #1;
    total_cnt++;
    if ({rf_writeEn, issue_ready} !== 2'b11) $display("FAIL same_edge_setup: en,issue_ready=%b expected 11", {rf_writeEn, issue_ready});
    else pass_cnt++;
    @(negedge clk_100MHz);
    issue_valid = 1'b0; rs2 = 7; #1;
    total_cnt++;
    if (rs2_busy !== 1'b1) $display("FAIL set_wins: rs2_busy=%b expected 1", rs2_busy);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    @(negedge clk_100MHz);
    issue_valid = 1'b1; issue_rd = 9;
    @(negedge clk_100MHz);
    issue_valid = 1'b0; lsu_valid = 1'b1; lsu_rd = 9; lsu_data = 32'hCAFE0009;
    reset = 1'b1;
    @(negedge clk_100MHz);
    reset = 1'b0; lsu_valid = 1'b0; rs1 = 9; rs2 = 7; model_last_lsu = 1'b0; #1;
    total_cnt++;
    if ({rf_writeEn, rs1_busy, rs2_busy} !== 3'b000)
      $display("FAIL mid_reset: en,rs1_busy,rs2_busy=%b expected 000", {rf_writeEn, rs1_busy, rs2_busy});
    else pass_cnt++;
    test_conflict(2);
  endtask

  task automatic test_back_to_back(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      bit win_lsu, any;
      @(negedge clk_100MHz);
      alu_valid = 1'($urandom_range(0, 1)); alu_rd = RW'($urandom_range(0, 31)); alu_data = $urandom();
      lsu_valid = 1'($urandom_range(0, 1)); lsu_rd = RW'($urandom_range(0, 31)); lsu_data = $urandom(); #1;
      any = alu_valid || lsu_valid;
      win_lsu = (alu_valid && lsu_valid) ? (RR ? !model_last_lsu : 1'b1) : lsu_valid;
      total_cnt++;
      if ({alu_ready, lsu_ready} !== {any && !win_lsu, any && win_lsu})
        $display("FAIL b2b_grant_%0d: alu,lsu ready=%b expected %b", i, {alu_ready, lsu_ready}, {any && !win_lsu, any && win_lsu});
      else pass_cnt++;
      if (any) begin
        model_last_lsu = win_lsu;
        if (win_lsu && lsu_rd != 0) push_write(lsu_rd, lsu_data);
        if (!win_lsu && alu_rd != 0) push_write(alu_rd, alu_data);
      end
    end
    @(negedge clk_100MHz);
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_issue_busy();
    test_alu_write();
    test_conflict(4);
    test_rd0();
    test_set_clear_same_edge();
    test_mid_reset();
    test_back_to_back(20);
    repeat (3) @(negedge clk_100MHz);
    #1;
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL sb_drain: %0d expected writes never seen, expected 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
